// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  localparam int DIV_MIN = 2;

  // High-phase length in clk periods: N/2 rounded up, written so it cannot overflow.
  function automatic logic [31:0] half_ratio(input logic [31:0] n);
    return (n >> 1) + {31'b0, n[0]};
  endfunction

endpackage

// File: rtl/clk_div_shaper.sv
// Output shaping for clk_div: passes p straight through for even ratios and
// ANDs it with a half-cycle-delayed copy for odd ratios to keep 50% duty.
module clk_div_shaper
  import clk_div_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic p,
  input  logic odd,
  output logic clk_div
);

  logic q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= p;
  end

  assign clk_div = odd ? (p & q) : p;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with valid/ready ratio loading,
// period-boundary ratio changes and glitch-free enable.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W    = 8,
  parameter int DIV_INIT = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [DIV_W-1:0] cur_div,
  output logic             clk_div,
  output logic             div_tick
);

  localparam logic [DIV_W-1:0] MIN_RATIO  = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] INIT_RATIO = DIV_W'(DIV_INIT);

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] pend;
  logic [DIV_W-1:0] div_nxt;
  logic [DIV_W-1:0] half_nxt;
  logic             pend_vld;
  logic             p;
  logic             p_nxt;
  logic             last;
  logic             running;
  logic             run_nxt;
  logic             xfer;
  logic             apply;

  // Next-cycle counter and p are computed against the ratio that will be in
  // force next cycle, so a freshly applied ratio shapes its first period.
  always_comb begin
    last     = (cnt == cur_div - 1'b1);
    running  = (state != IDLE);
    xfer     = cfg_valid && cfg_ready;
    apply    = pend_vld && (!running || last);
    div_nxt  = apply ? pend : cur_div;
    half_nxt = DIV_W'(half_ratio(32'(div_nxt)));
    cnt_nxt  = '0;
    run_nxt  = 1'b0;
    if (!running) begin
      run_nxt = en;
    end else begin
      cnt_nxt = last ? '0 : cnt + 1'b1;
      run_nxt = en || !last;
    end
    p_nxt = run_nxt && (cnt_nxt < half_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      p        <= 1'b0;
      div_tick <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      p        <= p_nxt;
      div_tick <= p_nxt & ~p;
      case (state)
        IDLE:     if (en) state <= RUN;
        RUN:      if (!en) state <= last ? IDLE : STOPPING;
        STOPPING: begin
          if (en)        state <= RUN;
          else if (last) state <= IDLE;
        end
        default:  state <= IDLE;
      endcase
    end
  end

  // Apply and accept are mutually exclusive: a pending ratio holds cfg_ready low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_div   <= INIT_RATIO;
      pend      <= INIT_RATIO;
      pend_vld  <= 1'b0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (apply) begin
        cur_div   <= pend;
        pend_vld  <= 1'b0;
        cfg_ready <= 1'b1;
      end else if (xfer && cfg_div >= MIN_RATIO) begin
        pend      <= cfg_div;
        pend_vld  <= 1'b1;
        cfg_ready <= 1'b0;
      end
      if (xfer && cfg_div < MIN_RATIO) cfg_err <= 1'b1;
    end
  end

  clk_div_shaper u_shaper (
    .clk     (clk),
    .rst_n   (rst_n),
    .p       (p),
    .odd     (cur_div[0]),
    .clk_div (clk_div)
  );

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: a monitor measures every clk_div pulse in
// half-cycles and checks it against expected pulses queued as stimulus is driven.
module tb_clk_div_prog;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic [7:0] cur_div;
  logic       clk_div;
  logic       div_tick;

  typedef struct {
    int hi;
    int lo;
  } pulse_t;

  pulse_t sb[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     n_ticks = 0;
  int     n_rises = 0;
  logic   mon_on = 1'b0;

  clk_div_prog #(.DIV_W(8), .DIV_INIT(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .cur_div   (cur_div),
    .clk_div   (clk_div),
    .div_tick  (div_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected pulse of ratio n followed by ratio n_next, in half clk periods.
  // An odd ratio rises half a cycle late, which moves the preceding low edge.
  function automatic pulse_t mk(input int n, input int n_next);
    pulse_t e;
    e.hi = n;
    e.lo = (n_next == 0) ? 0 : n + (n_next % 2) - (n % 2);
    return e;
  endfunction

  // Pulse monitor: samples 1 time unit after every clk edge.
  pulse_t cur_e;
  pulse_t pend_e;
  logic   have_pend = 1'b0;
  logic   prev_lvl = 1'b0;
  int     run_len = 0;

  always begin
    @(clk);
    #1;
    if (!mon_on) begin
      prev_lvl  = clk_div;
      run_len   = 0;
      have_pend = 1'b0;
    end else begin
      if (clk && div_tick) n_ticks++;
      if (clk_div !== prev_lvl) begin
        if (prev_lvl) begin
          check_output("pulse_expected", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            cur_e = sb.pop_front();
            check_output("high_halves", run_len, cur_e.hi);
            pend_e    = cur_e;
            have_pend = 1'b1;
          end
        end else begin
          n_rises++;
          check_output("tick_at_rise", 32'(div_tick), 32'd1);
          if (have_pend && pend_e.lo != 0) check_output("low_halves", run_len, pend_e.lo);
          have_pend = 1'b0;
        end
        run_len  = 1;
        prev_lvl = clk_div;
      end else begin
        run_len++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    #12;
    check_output("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check_output("rst_cfg_err",   32'(cfg_err),   32'd0);
    check_output("rst_cur_div",   32'(cur_div),   32'd6);
    check_output("rst_clk_div",   32'(clk_div),   32'd0);
    check_output("rst_div_tick",  32'(div_tick),  32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    step(1);

    // Free-running at the reset ratio of 6.
    en = 1'b1;
    sb.push_back(mk(6, 6));
    sb.push_back(mk(6, 6));
    sb.push_back(mk(6, 5));
    step(1);
    check_output("first_tick", 32'(div_tick), 32'd1);
    check_output("first_high", 32'(clk_div),  32'd1);
    step(13);

    // Load 5 mid-period; the running 6-period must finish first.
    cfg_valid = 1'b1;
    cfg_div   = 8'd5;
    sb.push_back(mk(5, 5));
    sb.push_back(mk(5, 4));
    step(1);
    cfg_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_output("ready_low_pending", 32'(cfg_ready), 32'd0);
      check_output("old_div_kept",      32'(cur_div),   32'd6);
      step(1);
    end
    check_output("ready_after_apply", 32'(cfg_ready), 32'd1);
    check_output("applied_5",         32'(cur_div),   32'd5);

    // Illegal ratios are rejected with a single-cycle error pulse each.
    cfg_valid = 1'b1;
    cfg_div   = 8'd1;
    step(1);
    check_output("err_n1",   32'(cfg_err),   32'd1);
    check_output("ready_n1", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b0;
    step(1);
    check_output("err_n1_once", 32'(cfg_err), 32'd0);
    cfg_valid = 1'b1;
    cfg_div   = 8'd0;
    step(1);
    check_output("err_n0",   32'(cfg_err),   32'd1);
    check_output("ready_n0", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b0;
    step(1);
    check_output("err_n0_once",   32'(cfg_err),   32'd0);
    check_output("div_unchanged", 32'(cur_div),   32'd5);
    check_output("ready_idle",    32'(cfg_ready), 32'd1);

    // Switch to 4, then drop enable at cnt=1 of the first 4-period.
    cfg_valid = 1'b1;
    cfg_div   = 8'd4;
    sb.push_back(mk(4, 0));
    step(1);
    cfg_valid = 1'b0;
    check_output("ready_low_4", 32'(cfg_ready), 32'd0);
    step(6);
    check_output("applied_4", 32'(cur_div), 32'd4);
    en = 1'b0;
    step(3);
    for (int i = 0; i < 3; i++) begin
      check_output("stopped_low", 32'(clk_div), 32'd0);
      step(1);
    end
    check_output("stopped_low", 32'(clk_div), 32'd0);
    en = 1'b1;
    sb.push_back(mk(4, 3));
    step(1);
    check_output("restart_tick", 32'(div_tick), 32'd1);
    check_output("restart_high", 32'(clk_div),  32'd1);

    // Back-to-back offers: 8 must wait until 3 has been applied.
    cfg_valid = 1'b1;
    cfg_div   = 8'd3;
    sb.push_back(mk(3, 8));
    step(1);
    check_output("ready_low_3", 32'(cfg_ready), 32'd0);
    cfg_div = 8'd8;
    sb.push_back(mk(8, 8));
    sb.push_back(mk(8, 7));
    for (int i = 0; i < 2; i++) begin
      step(1);
      check_output("ready_low_3", 32'(cfg_ready), 32'd0);
      check_output("still_4",     32'(cur_div),   32'd4);
    end
    step(1);
    check_output("applied_3",   32'(cur_div),   32'd3);
    check_output("ready_3_app", 32'(cfg_ready), 32'd1);
    step(1);
    check_output("took_8",     32'(cfg_ready), 32'd0);
    check_output("still_3",    32'(cur_div),   32'd3);
    cfg_valid = 1'b0;
    step(2);
    check_output("applied_8", 32'(cur_div),   32'd8);
    check_output("ready_8",   32'(cfg_ready), 32'd1);
    step(8);

    // Move to 7, then reset in the middle of its first high phase.
    cfg_valid = 1'b1;
    cfg_div   = 8'd7;
    step(1);
    cfg_valid = 1'b0;
    step(7);
    check_output("applied_7", 32'(cur_div), 32'd7);
    @(negedge clk);
    #2;
    check_output("n7_high", 32'(clk_div),  32'd1);
    check_output("n7_tick", 32'(div_tick), 32'd1);
    mon_on = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_output("async_clk_div",  32'(clk_div),   32'd0);
    check_output("async_div_tick", 32'(div_tick),  32'd0);
    check_output("async_cfg_err",  32'(cfg_err),   32'd0);
    check_output("async_ready",    32'(cfg_ready), 32'd1);
    check_output("async_cur_div",  32'(cur_div),   32'd6);
    step(2);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    sb.push_back(mk(6, 6));
    sb.push_back(mk(6, 6));
    sb.push_back(mk(6, 0));
    step(1);
    check_output("post_rst_tick", 32'(div_tick), 32'd1);
    check_output("post_rst_high", 32'(clk_div),  32'd1);
    check_output("post_rst_div",  32'(cur_div),  32'd6);
    step(13);
    en = 1'b0;
    step(8);
    check_output("final_low", 32'(clk_div), 32'd0);
    step(2);
    check_output("all_pulses_seen", 32'(sb.size()), 32'd0);
    check_output("ticks_eq_rises",  32'(n_ticks),   32'(n_rises));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
